// File: rtl/snoop_adapter_pkg.sv
// Shared types and elaboration helpers for the P3 snooper/forwarder adapters.
// Holds the adapter state encoding and width derivations.
package snoop_adapter_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RECV,
    S_DROP,
    S_DONE
  } sn_state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int bpw(input int dw);
    return dw / 8;
  endfunction

  function automatic int inc_width(input int dw);
    return clog2(dw / 8) + 1;
  endfunction

  // Length must hold a full buffer of bytes without overflow.
  function automatic bit plen_ok(input int aw, input int dw, input int pw);
    return (pw >= aw + clog2(dw / 8) + 1) && (dw % 8 == 0);
  endfunction

endpackage

// File: rtl/snoop_adapter.sv
// Snooper-side packet buffer writer: stores words, counts bytes,
// truncates on overflow and drops packets that arrive without a buffer.
module snoop_adapter
  import snoop_adapter_pkg::*;
#(
  parameter int SN_FWD_ADDR_WIDTH = 8,
  parameter int SN_FWD_DATA_WIDTH = 64,
  parameter int PLEN_WIDTH        = 32,
  parameter int INC_WIDTH         = inc_width(SN_FWD_DATA_WIDTH)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [SN_FWD_DATA_WIDTH-1:0] sn_data,
  input  logic                         sn_vld,
  input  logic                         sn_last,
  input  logic [INC_WIDTH-1:0]         sn_bytes_vld,
  output logic                         sn_rdy,
  input  logic                         rdy_for_sn,
  output logic                         sn_done,
  output logic [PLEN_WIDTH-1:0]        sn_plen,
  output logic                         sn_trunc,
  output logic                         sn_dropped,
  output logic [SN_FWD_ADDR_WIDTH-1:0] sn_wr_addr,
  output logic [SN_FWD_DATA_WIDTH-1:0] sn_wr_data,
  output logic                         sn_wr_en
);

  localparam int AW  = SN_FWD_ADDR_WIDTH;
  localparam int DW  = SN_FWD_DATA_WIDTH;
  localparam int BPW = bpw(DW);
  localparam logic [AW-1:0] ADDR_MAX = '1;

  if (!plen_ok(AW, DW, PLEN_WIDTH)) begin : g_bad_cfg
    $error("snoop_adapter: illegal PLEN/DATA width");
  end

  sn_state_e             state_q, state_d;
  logic                  rdy_q, rdy_d;
  logic [AW-1:0]         addr_q, addr_d;
  logic [PLEN_WIDTH-1:0] len_q, len_d;
  logic                  full_q, full_d;
  logic                  done_q, done_d;
  logic                  trunc_q, trunc_d;
  logic                  drop_q, drop_d;
  logic                  wr_en_q, wr_en_d;
  logic [AW-1:0]         wr_addr_q, wr_addr_d;
  logic [DW-1:0]         wr_data_q, wr_data_d;

  logic                  acc;
  logic [PLEN_WIDTH-1:0] word_bytes;

  assign acc = sn_vld & rdy_q;

  always_comb begin
    word_bytes = PLEN_WIDTH'(BPW);
    if (sn_last && (sn_bytes_vld != '0)) begin
      word_bytes = PLEN_WIDTH'(sn_bytes_vld);
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    len_d     = len_q;
    full_d    = full_q;
    done_d    = 1'b0;
    trunc_d   = 1'b0;
    drop_d    = 1'b0;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    unique case (state_q)
      S_IDLE: begin
        if (acc && rdy_for_sn) begin
          wr_en_d   = 1'b1;
          wr_addr_d = '0;
          wr_data_d = sn_data;
          len_d     = word_bytes;
          addr_d    = (ADDR_MAX == '0) ? '0 : AW'(1);
          full_d    = !sn_last && (ADDR_MAX == '0);
          done_d    = sn_last;
          state_d   = sn_last ? S_DONE : S_RECV;
        end else if (acc) begin
          drop_d  = sn_last;
          state_d = sn_last ? S_IDLE : S_DROP;
        end
      end
      S_RECV: begin
        if (acc) begin
          if (!full_q) begin
            wr_en_d   = 1'b1;
            wr_addr_d = addr_q;
            wr_data_d = sn_data;
            len_d     = len_q + word_bytes;
            if (addr_q == ADDR_MAX) begin
              full_d = !sn_last;
            end else begin
              addr_d = addr_q + AW'(1);
            end
          end
          if (sn_last) begin
            done_d  = 1'b1;
            trunc_d = full_q;
            state_d = S_DONE;
          end
        end
      end
      S_DROP: begin
        if (acc && sn_last) begin
          drop_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    rdy_d = (state_d != S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      rdy_q     <= 1'b0;
      addr_q    <= '0;
      len_q     <= '0;
      full_q    <= 1'b0;
      done_q    <= 1'b0;
      trunc_q   <= 1'b0;
      drop_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      rdy_q     <= rdy_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      full_q    <= full_d;
      done_q    <= done_d;
      trunc_q   <= trunc_d;
      drop_q    <= drop_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign sn_rdy     = rdy_q;
  assign sn_done    = done_q;
  assign sn_plen    = len_q;
  assign sn_trunc   = trunc_q;
  assign sn_dropped = drop_q;
  assign sn_wr_en   = wr_en_q;
  assign sn_wr_addr = wr_addr_q;
  assign sn_wr_data = wr_data_q;

endmodule

// File: tb/tb_snoop_adapter.sv
// Bench for snoop_adapter: directed and random packets checked
// against a packet-level model of stored words, lengths and drops.
module tb_snoop_adapter;

  localparam int AW    = 3;
  localparam int DW    = 64;
  localparam int PW    = 32;
  localparam int IW    = 4;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] sn_data;
  logic          sn_vld;
  logic          sn_last;
  logic [IW-1:0] sn_bytes_vld;
  logic          sn_rdy;
  logic          rdy_for_sn;
  logic          sn_done;
  logic [PW-1:0] sn_plen;
  logic          sn_trunc;
  logic          sn_dropped;
  logic [AW-1:0] sn_wr_addr;
  logic [DW-1:0] sn_wr_data;
  logic          sn_wr_en;

  snoop_adapter #(
    .SN_FWD_ADDR_WIDTH(AW),
    .SN_FWD_DATA_WIDTH(DW),
    .PLEN_WIDTH(PW),
    .INC_WIDTH(IW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sn_data(sn_data),
    .sn_vld(sn_vld),
    .sn_last(sn_last),
    .sn_bytes_vld(sn_bytes_vld),
    .sn_rdy(sn_rdy),
    .rdy_for_sn(rdy_for_sn),
    .sn_done(sn_done),
    .sn_plen(sn_plen),
    .sn_trunc(sn_trunc),
    .sn_dropped(sn_dropped),
    .sn_wr_addr(sn_wr_addr),
    .sn_wr_data(sn_wr_data),
    .sn_wr_en(sn_wr_en)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            cyc;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  typedef struct {
    int            cyc;
    logic [PW-1:0] plen;
    logic          trunc;
  } done_t;

  typedef struct {
    int n;
    bit rfs;
    int lbv;
  } pkt_t;

  wr_t           wr_log[$];
  done_t         done_log[$];
  int            drop_log[$];
  int            rdy_low_log[$];
  pkt_t          pkts[$];
  logic [DW-1:0] word_q[$];
  int            acc_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_logs();
    wr_log.delete();
    done_log.delete();
    drop_log.delete();
    rdy_low_log.delete();
  endtask

  task automatic tick();
    @(negedge clk);
    if (sn_wr_en) wr_log.push_back('{cyc, sn_wr_addr, sn_wr_data});
    if (sn_done) done_log.push_back('{cyc, sn_plen, sn_trunc});
    if (sn_dropped) drop_log.push_back(cyc);
    if (!sn_rdy) rdy_low_log.push_back(cyc);
  endtask

  task automatic send_pkt(input int n, input bit rfs, input int lbv,
                          input int gap);
    int i;
    int guard;
    logic [DW-1:0] w;
    i = 0;
    guard = 0;
    while (i < n && guard < 40 * n + 40) begin
      tick();
      guard++;
      if (int'($urandom_range(0, 99)) < gap) begin
        sn_vld = 1'b0;
        sn_last = 1'b0;
        sn_bytes_vld = IW'($urandom);
      end else begin
        w = {$urandom, $urandom};
        sn_vld = 1'b1;
        sn_data = w;
        sn_last = (i == n - 1);
        sn_bytes_vld = (i == n - 1) ? IW'(lbv) : IW'($urandom);
        rdy_for_sn = (i == 0) ? rfs : 1'($urandom);
        if (sn_rdy) begin
          word_q.push_back(w);
          acc_q.push_back(cyc);
          i++;
        end
      end
    end
    chk("words_accepted", i, n);
    pkts.push_back('{n, rfs, lbv});
  endtask

  task automatic check_pkt();
    pkt_t p;
    int acc[16];
    logic [DW-1:0] words[16];
    int nwr;
    int exp_len;
    wr_t e;
    done_t d;
    p = pkts.pop_front();
    for (int j = 0; j < p.n; j++) begin
      acc[j] = acc_q.pop_front();
      words[j] = word_q.pop_front();
    end
    nwr = p.rfs ? ((p.n > DEPTH) ? DEPTH : p.n) : 0;
    exp_len = (p.n > DEPTH) ? DEPTH * 8
            : 8 * (p.n - 1) + ((p.lbv == 0) ? 8 : p.lbv);
    for (int j = 0; j < nwr; j++) begin
      chk("wr_present", wr_log.size() > 0, 1);
      if (wr_log.size() > 0) begin
        e = wr_log.pop_front();
        chk("wr_addr", e.addr, j);
        chk("wr_data", e.data, words[j]);
        chk("wr_latency", e.cyc, acc[j] + 1);
      end
    end
    if (p.rfs) begin
      chk("done_present", done_log.size() > 0, 1);
      if (done_log.size() > 0) begin
        d = done_log.pop_front();
        chk("plen", d.plen, exp_len);
        chk("trunc", d.trunc, p.n > DEPTH);
        chk("done_cycle", d.cyc, acc[p.n - 1] + 1);
        chk("rdy_low_present", rdy_low_log.size() > 0, 1);
        if (rdy_low_log.size() > 0) begin
          chk("rdy_low_cycle", rdy_low_log.pop_front(), d.cyc);
        end
      end
    end else begin
      chk("drop_present", drop_log.size() > 0, 1);
      if (drop_log.size() > 0) begin
        chk("drop_cycle", drop_log.pop_front(), acc[p.n - 1] + 1);
      end
    end
  endtask

  task automatic flush_check();
    tick();
    sn_vld = 1'b0;
    sn_last = 1'b0;
    tick();
    tick();
    tick();
    while (pkts.size() > 0) check_pkt();
    chk("no_extra_wr", wr_log.size(), 0);
    chk("no_extra_done", done_log.size(), 0);
    chk("no_extra_drop", drop_log.size(), 0);
    chk("no_extra_rdy_low", rdy_low_log.size(), 0);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_wr_en"}, sn_wr_en, 0);
    chk({tag, "_wr_addr"}, sn_wr_addr, 0);
    chk({tag, "_wr_data"}, sn_wr_data, 0);
    chk({tag, "_done"}, sn_done, 0);
    chk({tag, "_plen"}, sn_plen, 0);
    chk({tag, "_trunc"}, sn_trunc, 0);
    chk({tag, "_dropped"}, sn_dropped, 0);
    chk({tag, "_rdy"}, sn_rdy, 0);
  endtask

  initial begin
    int i;
    int guard;
    int last_a;
    rst = 1'b0;
    sn_data = '0;
    sn_vld = 1'b0;
    sn_last = 1'b0;
    sn_bytes_vld = '0;
    rdy_for_sn = 1'b0;

    tick();
    tick();
    check_idle_outputs("reset");
    rst = 1'b1;
    tick();
    chk("rdy_after_reset", sn_rdy, 1);
    clear_logs();

    send_pkt(1, 1'b1, 5, 0);
    flush_check();

    send_pkt(3, 1'b1, 0, 0);
    chk("b2b_accept", acc_q[2] - acc_q[0], 2);
    flush_check();

    send_pkt(10, 1'b1, 3, 0);
    flush_check();

    send_pkt(8, 1'b1, 8, 0);
    flush_check();

    send_pkt(4, 1'b0, 2, 0);
    flush_check();

    rdy_for_sn = 1'b1;
    i = 0;
    guard = 0;
    while (i < 2 && guard < 20) begin
      tick();
      guard++;
      sn_vld = 1'b1;
      sn_last = 1'b0;
      sn_data = {$urandom, $urandom};
      if (sn_rdy) i++;
    end
    chk("abort_words", i, 2);
    tick();
    sn_vld = 1'b0;
    rst = 1'b0;
    tick();
    check_idle_outputs("midreset");
    tick();
    rst = 1'b1;
    tick();
    chk("rdy_after_midreset", sn_rdy, 1);
    chk("abort_no_done", done_log.size(), 0);
    chk("abort_no_drop", drop_log.size(), 0);
    clear_logs();
    send_pkt(5, 1'b1, 7, 0);
    flush_check();

    send_pkt(2, 1'b1, 4, 0);
    last_a = acc_q[1];
    send_pkt(3, 1'b1, 1, 0);
    chk("accept_after_done", acc_q[2], last_a + 2);
    flush_check();

    for (int k = 0; k < 40; k++) begin
      send_pkt($urandom_range(1, 12), $urandom_range(0, 3) != 0,
               $urandom_range(0, 8), $urandom_range(0, 40));
      if ($urandom_range(0, 2) != 0) flush_check();
    end
    flush_check();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
